// File: rtl/vdp_pkg.sv
// Shared types and constants for the vdp99 VRAM path.
package vdp_pkg;

  localparam int unsigned VRAM_AW = 14;
  localparam int unsigned WAIT_W  = 5;

  typedef enum logic [1:0] {IDLE, PEND, RDAT} arb_state_e;
  typedef enum logic {OP_RD, OP_WR} op_kind_e;

endpackage

// File: rtl/vdp_cpu_port.sv
// CPU side of the VRAM data port: two-byte address setup, auto-increment
// address counter and the single-slot enqueue / overrun decision.
module vdp_cpu_port
  import vdp_pkg::*;
#(
  parameter int unsigned AW = VRAM_AW
) (
  input  logic          pxclk,
  input  logic          reset,
  input  logic          i_wr0_tick,
  input  logic          i_rd0_tick,
  input  logic          i_wr1_tick,
  input  logic          i_rd1_tick,
  input  logic [7:0]    i_din,
  input  logic          i_busy,
  output logic          o_enq_c,
  output op_kind_e      o_op_c,
  output logic [AW-1:0] o_addr_c,
  output logic [7:0]    o_data_c,
  output logic          o_overrun
);

  logic [AW-1:0] r_addr;
  logic [7:0]    r_lo;
  logic          r_flag;
  logic          r_overrun;

  // Ticks are exclusive by bus design; resolve collisions wr1 > wr0 > rd0 > rd1.
  logic w_wr1, w_wr0, w_rd0, w_rd1;
  assign w_wr1 = i_wr1_tick;
  assign w_wr0 = i_wr0_tick & ~i_wr1_tick;
  assign w_rd0 = i_rd0_tick & ~i_wr1_tick & ~i_wr0_tick;
  assign w_rd1 = i_rd1_tick & ~i_wr1_tick & ~i_wr0_tick & ~i_rd0_tick;

  logic [AW-1:0] w_setup_addr;
  logic          w_setup;
  logic          w_rd_setup;
  logic          w_req;
  logic [AW-1:0] w_op_addr;

  assign w_setup_addr = AW'({i_din[5:0], r_lo});
  assign w_setup      = w_wr1 & r_flag & ~i_din[7];
  assign w_rd_setup   = w_setup & ~i_din[6];
  assign w_req        = w_rd_setup | w_wr0 | w_rd0;
  assign w_op_addr    = w_setup ? w_setup_addr : r_addr;

  assign o_enq_c   = w_req & ~i_busy;
  assign o_op_c    = w_wr0 ? OP_WR : OP_RD;
  assign o_addr_c  = w_op_addr;
  assign o_data_c  = i_din;
  assign o_overrun = r_overrun;

  // Address and flag side effects apply even when the op itself is dropped.
  always_ff @(posedge pxclk) begin
    if (!reset) begin
      r_addr    <= '0;
      r_lo      <= 8'h00;
      r_flag    <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_overrun <= w_req & i_busy;
      if (w_wr1) begin
        r_flag <= ~r_flag;
        if (!r_flag) r_lo <= i_din;
      end else if (w_wr0 | w_rd0 | w_rd1) begin
        r_flag <= 1'b0;
      end
      if (w_req)        r_addr <= w_op_addr + AW'(1);
      else if (w_setup) r_addr <= w_setup_addr;
    end
  end

endmodule

// File: rtl/vdp_vram_arb.sv
// VRAM owner for the vdp99: CPU data port plus a display-priority arbiter
// with a bounded wait for the CPU.
module vdp_vram_arb
  import vdp_pkg::*;
#(
  parameter int unsigned AW           = VRAM_AW,
  parameter int unsigned CPU_MAX_WAIT = 31
) (
  input  logic          pxclk,
  input  logic          reset,
  input  logic          wr0_tick,
  input  logic          rd0_tick,
  input  logic          wr1_tick,
  input  logic          rd1_tick,
  input  logic [7:0]    din,
  output logic [7:0]    dout,
  output logic          cpu_busy,
  output logic          overrun,
  input  logic          disp_req,
  input  logic [AW-1:0] disp_addr,
  output logic          disp_gnt,
  output logic          disp_valid,
  output logic [7:0]    disp_data,
  output logic [AW-1:0] vram_addr,
  output logic          vram_we,
  output logic [7:0]    vram_wdata,
  input  logic [7:0]    vram_rdata
);

  arb_state_e        r_state;
  op_kind_e          r_op;
  logic [AW-1:0]     r_paddr;
  logic [7:0]        r_pdata;
  logic [WAIT_W-1:0] r_wait;
  logic [7:0]        r_dout;
  logic              r_disp_valid;

  logic          w_busy;
  logic          w_enq;
  op_kind_e      w_enq_op;
  logic [AW-1:0] w_enq_addr;
  logic [7:0]    w_enq_data;
  logic          w_cpu_wins;
  logic          w_cpu_wr;

  assign w_busy = (r_state != IDLE);

  vdp_cpu_port #(.AW(AW)) u_cpu_port (
    .pxclk      (pxclk),
    .reset      (reset),
    .i_wr0_tick (wr0_tick),
    .i_rd0_tick (rd0_tick),
    .i_wr1_tick (wr1_tick),
    .i_rd1_tick (rd1_tick),
    .i_din      (din),
    .i_busy     (w_busy),
    .o_enq_c    (w_enq),
    .o_op_c     (w_enq_op),
    .o_addr_c   (w_enq_addr),
    .o_data_c   (w_enq_data),
    .o_overrun  (overrun)
  );

  // Display owns the port unless the CPU has waited out its budget.
  assign w_cpu_wins = (r_state == PEND) &
                      (~disp_req | (r_wait == WAIT_W'(CPU_MAX_WAIT)));
  assign w_cpu_wr   = w_cpu_wins & (r_op == OP_WR);

  assign disp_gnt   = disp_req & ~w_cpu_wins;
  assign vram_addr  = w_cpu_wins ? r_paddr : disp_addr;
  assign vram_we    = w_cpu_wr;
  assign vram_wdata = w_cpu_wr ? r_pdata : 8'h00;
  assign disp_valid = r_disp_valid;
  assign disp_data  = r_disp_valid ? vram_rdata : 8'h00;
  assign dout       = r_dout;
  assign cpu_busy   = w_busy;

  always_ff @(posedge pxclk) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_op         <= OP_RD;
      r_paddr      <= '0;
      r_pdata      <= 8'h00;
      r_wait       <= '0;
      r_dout       <= 8'h00;
      r_disp_valid <= 1'b0;
    end else begin
      r_disp_valid <= disp_gnt;
      case (r_state)
        IDLE: begin
          if (w_enq) begin
            r_op    <= w_enq_op;
            r_paddr <= w_enq_addr;
            r_pdata <= w_enq_data;
            r_wait  <= '0;
            r_state <= PEND;
          end
        end
        PEND: begin
          if (w_cpu_wins) begin
            r_wait  <= '0;
            r_state <= (r_op == OP_WR) ? IDLE : RDAT;
          end else begin
            r_wait <= r_wait + WAIT_W'(1);
          end
        end
        RDAT: begin
          r_dout  <= vram_rdata;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vdp_vram_arb.sv
// Self-checking bench for vdp_vram_arb with a behavioural 16K x 8 VRAM.
module tb_vdp_vram_arb;

  localparam int K_WR0 = 0;
  localparam int K_RD0 = 1;
  localparam int K_WR1 = 2;
  localparam int K_RD1 = 3;

  logic        pxclk = 1'b0;
  logic        reset = 1'b0;
  logic        wr0_tick = 1'b0, rd0_tick = 1'b0, wr1_tick = 1'b0, rd1_tick = 1'b0;
  logic [7:0]  din = 8'h00;
  logic [7:0]  dout;
  logic        cpu_busy, overrun;
  logic        disp_req = 1'b0;
  logic [13:0] disp_addr = 14'h0000;
  logic        disp_gnt, disp_valid;
  logic [7:0]  disp_data;
  logic [13:0] vram_addr;
  logic        vram_we;
  logic [7:0]  vram_wdata;
  logic [7:0]  vram_rdata = 8'h00;

  always #20 pxclk = ~pxclk;

  vdp_vram_arb dut (
    .pxclk(pxclk), .reset(reset),
    .wr0_tick(wr0_tick), .rd0_tick(rd0_tick), .wr1_tick(wr1_tick), .rd1_tick(rd1_tick),
    .din(din), .dout(dout), .cpu_busy(cpu_busy), .overrun(overrun),
    .disp_req(disp_req), .disp_addr(disp_addr), .disp_gnt(disp_gnt),
    .disp_valid(disp_valid), .disp_data(disp_data),
    .vram_addr(vram_addr), .vram_we(vram_we), .vram_wdata(vram_wdata),
    .vram_rdata(vram_rdata)
  );

  // Behavioural VRAM with a backdoor preload port.
  logic [7:0]  mem [16384] = '{default: 8'h00};
  logic        pl_en = 1'b0;
  logic [13:0] pl_addr = 14'h0000;
  logic [7:0]  pl_data = 8'h00;

  always @(posedge pxclk) begin
    if (pl_en)        mem[pl_addr] <= pl_data;
    else if (vram_we) mem[vram_addr] <= vram_wdata;
    vram_rdata <= mem[vram_addr];
  end

  int         n_vec = 0;
  int         n_err = 0;
  logic [7:0] exp_q[$];
  logic [7:0] disp_q[$];
  logic [7:0] mon_e;
  bit         mon_en = 1'b0;

  // Display scoreboard: a grant pushes the byte the model will return next cycle.
  always @(negedge pxclk) begin
    if (mon_en) begin
      if (disp_q.size() > 0) begin
        mon_e = disp_q.pop_front();
        n_vec++;
        if (disp_valid !== 1'b1 || disp_data !== mon_e) begin
          n_err++;
          $display("FAIL disp_fetch t=%0t: valid=%b data=%h, required valid=1 data=%h",
                   $time, disp_valid, disp_data, mon_e);
        end
      end else begin
        n_vec++;
        if (disp_valid !== 1'b0) begin
          n_err++;
          $display("FAIL disp_valid_idle t=%0t: valid=%b, required 0", $time, disp_valid);
        end
      end
      if (disp_gnt === 1'b1) disp_q.push_back(mem[disp_addr]);
    end
  end

  task automatic cyc();
    @(posedge pxclk);
    #1;
  endtask

  task automatic tick(input int kind, input logic [7:0] d);
    din = d;
    case (kind)
      K_WR0:   wr0_tick = 1'b1;
      K_RD0:   rd0_tick = 1'b1;
      K_WR1:   wr1_tick = 1'b1;
      default: rd1_tick = 1'b1;
    endcase
    cyc();
    wr0_tick = 1'b0; rd0_tick = 1'b0; wr1_tick = 1'b0; rd1_tick = 1'b0;
  endtask

  task automatic preload(input logic [13:0] a, input logic [7:0] d);
    pl_addr = a; pl_data = d; pl_en = 1'b1;
    cyc();
    pl_en = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(negedge pxclk);
      if (cpu_busy === 1'b0) begin ok = 1'b1; break; end
      cyc();
    end
    cyc();
    n_vec++;
    if (!ok) begin
      n_err++;
      $display("FAIL %s_timeout: cpu_busy=%b, required 0 within 64 cycles", name, cpu_busy);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) cyc();
    @(negedge pxclk);
    n_vec++;
    if (dout !== 8'h00) begin n_err++; $display("FAIL reset_dout: got %h, required 00", dout); end
    n_vec++;
    if ({cpu_busy, overrun, disp_valid} !== 3'b000) begin
      n_err++; $display("FAIL reset_flags: busy/ovr/valid=%b, required 000", {cpu_busy, overrun, disp_valid});
    end
    n_vec++;
    if (vram_we !== 1'b0 || vram_addr !== 14'h0 || vram_wdata !== 8'h00) begin
      n_err++; $display("FAIL reset_vram: we=%b addr=%h wdata=%h, required 0/0000/00", vram_we, vram_addr, vram_wdata);
    end
    reset = 1'b1;
    cyc();
    mon_en = 1'b1;
  endtask

  task automatic test_read_setup();
    logic [7:0] e;
    preload(14'h1234, 8'hA5);
    preload(14'h1235, 8'h5A);
    tick(K_WR1, 8'h34);
    tick(K_WR1, 8'h12);
    exp_q.push_back(8'hA5);
    @(negedge pxclk);
    n_vec++;
    if (vram_addr !== 14'h1234 || vram_we !== 1'b0 || cpu_busy !== 1'b1) begin
      n_err++; $display("FAIL setup_issue: addr=%h we=%b busy=%b, required 1234/0/1", vram_addr, vram_we, cpu_busy);
    end
    cyc();
    wait_idle("setup_read");
    e = exp_q.pop_front();
    n_vec++;
    if (dout !== e) begin n_err++; $display("FAIL setup_dout: got %h, required %h", dout, e); end
    tick(K_RD0, 8'h00);
    exp_q.push_back(8'h5A);
    @(negedge pxclk);
    n_vec++;
    if (dout !== 8'hA5 || vram_addr !== 14'h1235) begin
      n_err++; $display("FAIL rd0_hold: dout=%h addr=%h, required A5/1235", dout, vram_addr);
    end
    cyc();
    wait_idle("rd0_prefetch");
    e = exp_q.pop_front();
    n_vec++;
    if (dout !== e) begin n_err++; $display("FAIL rd0_prefetch: got %h, required %h", dout, e); end
  endtask

  task automatic test_write_wrap();
    tick(K_WR1, 8'hFF);
    tick(K_WR1, 8'h7F);
    tick(K_WR0, 8'h11);
    wait_idle("wrap_w1");
    tick(K_WR0, 8'h22);
    wait_idle("wrap_w2");
    n_vec++;
    if (mem[14'h3FFF] !== 8'h11) begin n_err++; $display("FAIL wrap_3fff: got %h, required 11", mem[14'h3FFF]); end
    n_vec++;
    if (mem[14'h0000] !== 8'h22) begin n_err++; $display("FAIL wrap_0000: got %h, required 22", mem[14'h0000]); end
  endtask

  task automatic test_reg_write();
    logic [7:0] e;
    tick(K_WR1, 8'h34);
    tick(K_WR1, 8'h12);
    exp_q.push_back(8'hA5);
    wait_idle("reg_setup");
    e = exp_q.pop_front();
    n_vec++;
    if (dout !== e) begin n_err++; $display("FAIL reg_setup_dout: got %h, required %h", dout, e); end
    tick(K_WR1, 8'h07);
    tick(K_WR1, 8'h87);
    tick(K_WR0, 8'h55);
    wait_idle("reg_wr0");
    n_vec++;
    if (mem[14'h1235] !== 8'h55) begin n_err++; $display("FAIL reg_keep_addr: got %h, required 55", mem[14'h1235]); end
    tick(K_WR1, 8'h34);
    tick(K_RD1, 8'h00);
    tick(K_WR1, 8'h00);
    tick(K_WR1, 8'h41);
    tick(K_WR0, 8'h77);
    wait_idle("rd1_clear");
    n_vec++;
    if (mem[14'h0100] !== 8'h77 || mem[14'h0035] !== 8'h00) begin
      n_err++; $display("FAIL rd1_clear_flag: [0100]=%h [0035]=%h, required 77/00", mem[14'h0100], mem[14'h0035]);
    end
  endtask

  task automatic test_starvation();
    preload(14'h2000, 8'hC3);
    tick(K_WR1, 8'h00);
    tick(K_WR1, 8'h41);
    disp_addr = 14'h2000;
    disp_req  = 1'b1;
    cyc();
    cyc();
    tick(K_WR0, 8'h66);
    for (int k = 0; k < 36; k++) begin
      @(negedge pxclk);
      n_vec++;
      if (disp_gnt !== (k != 31) || vram_we !== (k == 31)) begin
        n_err++; $display("FAIL starve_k%0d: gnt=%b we=%b, required gnt=%b we=%b", k, disp_gnt, vram_we, k != 31, k == 31);
      end
      if (k == 31) begin
        n_vec++;
        if (vram_addr !== 14'h0100 || vram_wdata !== 8'h66) begin
          n_err++; $display("FAIL starve_write: addr=%h wdata=%h, required 0100/66", vram_addr, vram_wdata);
        end
      end
      cyc();
    end
    disp_req = 1'b0;
    cyc();
    n_vec++;
    if (mem[14'h0100] !== 8'h66) begin n_err++; $display("FAIL starve_mem: got %h, required 66", mem[14'h0100]); end
  endtask

  task automatic test_overrun();
    int n_ovr = 0;
    tick(K_WR1, 8'h00);
    tick(K_WR1, 8'h42);
    disp_addr = 14'h2000;
    disp_req  = 1'b1;
    cyc();
    tick(K_WR0, 8'h01);
    for (int i = 0; i < 40; i++) begin
      if (i == 1) begin din = 8'h02; wr0_tick = 1'b1; end
      @(negedge pxclk);
      if (overrun === 1'b1) n_ovr++;
      cyc();
      wr0_tick = 1'b0;
    end
    disp_req = 1'b0;
    wait_idle("overrun");
    n_vec++;
    if (n_ovr != 1) begin n_err++; $display("FAIL overrun_pulses: got %0d, required 1", n_ovr); end
    n_vec++;
    if (mem[14'h0200] !== 8'h01 || mem[14'h0201] !== 8'h00) begin
      n_err++; $display("FAIL overrun_mem: [0200]=%h [0201]=%h, required 01/00", mem[14'h0200], mem[14'h0201]);
    end
    tick(K_WR0, 8'h03);
    wait_idle("overrun_addr");
    n_vec++;
    if (mem[14'h0202] !== 8'h03) begin n_err++; $display("FAIL overrun_addr: [0202]=%h, required 03", mem[14'h0202]); end
  endtask

  task automatic test_reset_mid_read();
    tick(K_WR1, 8'h34);
    tick(K_WR1, 8'h12);
    cyc();
    reset = 1'b0;
    @(negedge pxclk);
    @(negedge pxclk);
    n_vec++;
    if (dout !== 8'h00 || cpu_busy !== 1'b0 || vram_we !== 1'b0) begin
      n_err++; $display("FAIL reset_mid_read: dout=%h busy=%b we=%b, required 00/0/0", dout, cpu_busy, vram_we);
    end
    reset = 1'b1;
    cyc();
    cyc();
    n_vec++;
    if (mem[14'h1234] !== 8'hA5 || cpu_busy !== 1'b0) begin
      n_err++; $display("FAIL reset_no_write: [1234]=%h busy=%b, required A5/0", mem[14'h1234], cpu_busy);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_read_setup();
    test_write_wrap();
    test_reg_write();
    test_starvation();
    test_overrun();
    test_reset_mid_read();
    repeat (2) cyc();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
